// File: rtl/led_ctrl_pkg.sv
// LED control shared types: behaviour encoding and bound-handling modes
// used by the flasher FSM and the LED level counter.
`default_nettype none

package led_ctrl_pkg;

  typedef enum logic [1:0] {
    DECREASE = 2'b00,
    INCREASE = 2'b01,
    LOAD     = 2'b10,
    PASS     = 2'b11
  } led_bhv_e;

  localparam int MODE_SAT  = 0;
  localparam int MODE_WRAP = 1;

endpackage

`default_nettype wire

// File: rtl/led_next_calc.sv
// Combinational next-count and pulse computation for the LED level counter;
// all arithmetic is one bit wider than the count so nothing wraps silently.
`default_nettype none

module led_next_calc
  import led_ctrl_pkg::*;
#(
  parameter int CNT_W   = 5,
  parameter int STEP    = 1,
  parameter int WRAP_EN = MODE_SAT
) (
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] lo_bound,
  input  logic [CNT_W-1:0] hi_eff,
  input  logic [CNT_W-1:0] load_val,
  input  led_bhv_e         led_bhv,
  output logic [CNT_W-1:0] next_count,
  output logic             hit_min_nxt,
  output logic             hit_max_nxt,
  output logic             wrapped_nxt
);

  localparam logic [CNT_W:0] STEP_EXT = (CNT_W+1)'(STEP);

  logic [CNT_W:0]          sum;
  logic signed [CNT_W+1:0] diff;
  logic signed [CNT_W+1:0] lo_s;
  logic                    wrap_ok;

  always_comb begin
    sum         = {1'b0, count} + STEP_EXT;
    diff        = $signed({2'b00, count}) - $signed({1'b0, STEP_EXT});
    lo_s        = $signed({2'b00, lo_bound});
    // A wrap onto a degenerate (lo == hi) range would be a no-op, so it holds quietly.
    wrap_ok     = (WRAP_EN == MODE_WRAP) && (lo_bound != hi_eff);
    next_count  = count;
    hit_min_nxt = 1'b0;
    hit_max_nxt = 1'b0;
    wrapped_nxt = 1'b0;

    case (led_bhv)
      INCREASE: begin
        if (count > hi_eff) begin
          next_count  = hi_eff;
          hit_max_nxt = 1'b1;
        end else if (sum < {1'b0, hi_eff}) begin
          next_count = sum[CNT_W-1:0];
        end else if (count != hi_eff) begin
          next_count  = hi_eff;
          hit_max_nxt = 1'b1;
        end else if (wrap_ok) begin
          next_count  = lo_bound;
          wrapped_nxt = 1'b1;
        end
      end

      DECREASE: begin
        if (count < lo_bound) begin
          next_count  = lo_bound;
          hit_min_nxt = 1'b1;
        end else if (diff > lo_s) begin
          next_count = diff[CNT_W-1:0];
        end else if (count != lo_bound) begin
          next_count  = lo_bound;
          hit_min_nxt = 1'b1;
        end else if (wrap_ok) begin
          next_count  = hi_eff;
          wrapped_nxt = 1'b1;
        end
      end

      LOAD: begin
        if (load_val < lo_bound) begin
          next_count = lo_bound;
        end else if (load_val > hi_eff) begin
          next_count = hi_eff;
        end else begin
          next_count = load_val;
        end
        // hit_max wins when lo == hi so the pulses stay mutually exclusive.
        if (next_count != count) begin
          if (next_count == hi_eff) begin
            hit_max_nxt = 1'b1;
          end else if (next_count == lo_bound) begin
            hit_min_nxt = 1'b1;
          end
        end
      end

      default: begin
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/led_level_counter.sv
// LED level counter: bounded up/down/load counter with bound flags and
// one-cycle hit/wrap pulses, registered on the divided clock.
`default_nettype none

module led_level_counter
  import led_ctrl_pkg::*;
#(
  parameter int LED_NUMBER = 16,
  parameter int CNT_W      = $clog2(LED_NUMBER + 1),
  parameter int STEP       = 1,
  parameter int WRAP_EN    = MODE_SAT,
  parameter int RESET_VAL  = 0
) (
  input  logic             div_clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       led_bhv,
  input  logic [CNT_W-1:0] lo_bound,
  input  logic [CNT_W-1:0] hi_bound,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             at_min,
  output logic             at_max,
  output logic             hit_min,
  output logic             hit_max,
  output logic             wrapped,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] LED_MAX   = CNT_W'(LED_NUMBER);
  localparam logic [CNT_W-1:0] RST_COUNT = CNT_W'(RESET_VAL);

  logic [CNT_W-1:0] count_q, count_d;
  logic             hit_min_q, hit_min_d;
  logic             hit_max_q, hit_max_d;
  logic             wrapped_q, wrapped_d;

  logic [CNT_W-1:0] hi_eff;
  logic [CNT_W-1:0] calc_count;
  logic             calc_hit_min;
  logic             calc_hit_max;
  logic             calc_wrapped;
  logic             hold;

  always_comb begin
    hi_eff  = (hi_bound > LED_MAX) ? LED_MAX : hi_bound;
    cfg_err = (lo_bound > hi_eff);
    at_min  = (count_q == lo_bound);
    at_max  = (count_q == hi_eff);
  end

  led_next_calc #(
    .CNT_W   (CNT_W),
    .STEP    (STEP),
    .WRAP_EN (WRAP_EN)
  ) u_next_calc (
    .count       (count_q),
    .lo_bound    (lo_bound),
    .hi_eff      (hi_eff),
    .load_val    (load_val),
    .led_bhv     (led_bhv_e'(led_bhv)),
    .next_count  (calc_count),
    .hit_min_nxt (calc_hit_min),
    .hit_max_nxt (calc_hit_max),
    .wrapped_nxt (calc_wrapped)
  );

  always_comb begin
    hold      = !en || cfg_err || (led_bhv == PASS);
    count_d   = count_q;
    hit_min_d = 1'b0;
    hit_max_d = 1'b0;
    wrapped_d = 1'b0;
    if (!hold) begin
      count_d   = calc_count;
      hit_min_d = calc_hit_min;
      hit_max_d = calc_hit_max;
      wrapped_d = calc_wrapped;
    end
  end

  always_ff @(posedge div_clk) begin
    if (!rst) begin
      count_q   <= RST_COUNT;
      hit_min_q <= 1'b0;
      hit_max_q <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      hit_min_q <= hit_min_d;
      hit_max_q <= hit_max_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign count   = count_q;
  assign hit_min = hit_min_q;
  assign hit_max = hit_max_q;
  assign wrapped = wrapped_q;

  a_bhv_known: assert property (@(posedge div_clk) disable iff (!rst) !$isunknown(led_bhv));

endmodule

`default_nettype wire

// File: tb/tb_led_level_counter.sv
// Directed self-checking bench for led_level_counter: three instances cover
// saturate/STEP=1, saturate/STEP=3 and wrap/RESET_VAL=4 configurations.
`default_nettype none

module tb_led_level_counter;

  localparam logic [1:0] B_DEC  = 2'b00;
  localparam logic [1:0] B_INC  = 2'b01;
  localparam logic [1:0] B_LOAD = 2'b10;
  localparam logic [1:0] B_PASS = 2'b11;

  logic div_clk = 1'b0;
  always #5 div_clk = ~div_clk;

  int checks = 0;
  int errors = 0;

  // instance A: STEP=1, saturate
  logic       a_rst, a_en;
  logic [1:0] a_bhv;
  logic [4:0] a_lo, a_hi, a_ld, a_count;
  logic       a_at_min, a_at_max, a_hit_min, a_hit_max, a_wrapped, a_cfg_err;
  // instance B: STEP=3, saturate
  logic       b_rst, b_en;
  logic [1:0] b_bhv;
  logic [4:0] b_lo, b_hi, b_ld, b_count;
  logic       b_at_min, b_at_max, b_hit_min, b_hit_max, b_wrapped, b_cfg_err;
  // instance C: STEP=1, wrap, reset value 4
  logic       c_rst, c_en;
  logic [1:0] c_bhv;
  logic [4:0] c_lo, c_hi, c_ld, c_count;
  logic       c_at_min, c_at_max, c_hit_min, c_hit_max, c_wrapped, c_cfg_err;

  led_level_counter #(.LED_NUMBER(16), .STEP(1), .WRAP_EN(0), .RESET_VAL(0)) dut_a (
    .div_clk(div_clk), .rst(a_rst), .en(a_en), .led_bhv(a_bhv),
    .lo_bound(a_lo), .hi_bound(a_hi), .load_val(a_ld), .count(a_count),
    .at_min(a_at_min), .at_max(a_at_max), .hit_min(a_hit_min),
    .hit_max(a_hit_max), .wrapped(a_wrapped), .cfg_err(a_cfg_err));

  led_level_counter #(.LED_NUMBER(16), .STEP(3), .WRAP_EN(0), .RESET_VAL(0)) dut_b (
    .div_clk(div_clk), .rst(b_rst), .en(b_en), .led_bhv(b_bhv),
    .lo_bound(b_lo), .hi_bound(b_hi), .load_val(b_ld), .count(b_count),
    .at_min(b_at_min), .at_max(b_at_max), .hit_min(b_hit_min),
    .hit_max(b_hit_max), .wrapped(b_wrapped), .cfg_err(b_cfg_err));

  led_level_counter #(.LED_NUMBER(16), .STEP(1), .WRAP_EN(1), .RESET_VAL(4)) dut_c (
    .div_clk(div_clk), .rst(c_rst), .en(c_en), .led_bhv(c_bhv),
    .lo_bound(c_lo), .hi_bound(c_hi), .load_val(c_ld), .count(c_count),
    .at_min(c_at_min), .at_max(c_at_max), .hit_min(c_hit_min),
    .hit_max(c_hit_max), .wrapped(c_wrapped), .cfg_err(c_cfg_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int cnt, input logic hmin, input logic hmax, input logic wr);
    chk({tag, ".count"},   a_count,   cnt);
    chk({tag, ".hit_min"}, a_hit_min, hmin);
    chk({tag, ".hit_max"}, a_hit_max, hmax);
    chk({tag, ".wrapped"}, a_wrapped, wr);
  endtask

  task automatic chk_b(input string tag, input int cnt, input logic hmin, input logic hmax, input logic wr);
    chk({tag, ".count"},   b_count,   cnt);
    chk({tag, ".hit_min"}, b_hit_min, hmin);
    chk({tag, ".hit_max"}, b_hit_max, hmax);
    chk({tag, ".wrapped"}, b_wrapped, wr);
  endtask

  task automatic chk_c(input string tag, input int cnt, input logic hmin, input logic hmax, input logic wr);
    chk({tag, ".count"},   c_count,   cnt);
    chk({tag, ".hit_min"}, c_hit_min, hmin);
    chk({tag, ".hit_max"}, c_hit_max, hmax);
    chk({tag, ".wrapped"}, c_wrapped, wr);
  endtask

  initial begin
    a_rst = 1'b0; a_en = 1'b1; a_bhv = B_INC;  a_lo = 5'd0; a_hi = 5'd16; a_ld = 5'd0;
    b_rst = 1'b0; b_en = 1'b1; b_bhv = B_PASS; b_lo = 5'd0; b_hi = 5'd16; b_ld = 5'd0;
    c_rst = 1'b0; c_en = 1'b1; c_bhv = B_PASS; c_lo = 5'd1; c_hi = 5'd5;  c_ld = 5'd0;

    // Reset held for two edges while INCREASE is requested
    tick(); tick();
    chk_a("rst", 0, 1'b0, 1'b0, 1'b0);
    chk("rst.at_min", a_at_min, 1'b1);
    chk("rst.at_max", a_at_max, 1'b0);
    a_rst = 1'b1;
    tick();
    chk_a("rst_release", 1, 1'b0, 1'b0, 1'b0);
    repeat (6) tick();
    chk_a("ramp7", 7, 1'b0, 1'b0, 1'b0);
    a_rst = 1'b0;
    tick();
    chk_a("rst_midramp", 0, 1'b0, 1'b0, 1'b0);
    a_rst = 1'b1;

    // Saturate up to 16, single hit_max
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("sat_up%0d.count", i), a_count, (i < 16) ? i : 16);
      chk($sformatf("sat_up%0d.hit_max", i), a_hit_max, (i == 16));
    end
    chk("sat_up.at_max", a_at_max, 1'b1);

    // Down to floor at lo=4, single hit_min
    a_lo = 5'd4; a_bhv = B_DEC;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk($sformatf("dn%0d.count", k), a_count, (16 - k > 4) ? 16 - k : 4);
      chk($sformatf("dn%0d.hit_min", k), a_hit_min, (k == 12));
      chk($sformatf("dn%0d.hit_max", k), a_hit_max, 1'b0);
    end
    chk("dn.at_min", a_at_min, 1'b1);

    // LOAD clamps
    a_bhv = B_LOAD; a_ld = 5'd20;
    tick();
    chk_a("load20", 16, 1'b0, 1'b1, 1'b0);
    a_ld = 5'd2;
    tick();
    chk_a("load2", 4, 1'b1, 1'b0, 1'b0);

    // Enable gating
    a_en = 1'b0; a_bhv = B_INC;
    tick();
    chk_a("en0", 4, 1'b0, 1'b0, 1'b0);
    a_en = 1'b1;

    // Configuration error holds the count
    a_lo = 5'd10; a_hi = 5'd3;
    #1;
    chk("cfg_err.flag", a_cfg_err, 1'b1);
    tick();
    chk_a("cfg_err", 4, 1'b0, 1'b0, 1'b0);

    // hi_bound above LED_NUMBER acts as 16
    a_lo = 5'd0; a_hi = 5'd31; a_bhv = B_LOAD; a_ld = 5'd31;
    #1;
    chk("hi31.cfg_err", a_cfg_err, 1'b0);
    tick();
    chk_a("hi31_load", 16, 1'b0, 1'b1, 1'b0);
    chk("hi31.at_max", a_at_max, 1'b1);
    a_bhv = B_PASS;
    tick();
    chk_a("pass", 16, 1'b0, 1'b0, 1'b0);

    // STEP=3 clipping at both bounds
    b_rst = 1'b1; b_bhv = B_LOAD; b_ld = 5'd14;
    tick();
    chk_b("s3_load14", 14, 1'b0, 1'b0, 1'b0);
    b_bhv = B_INC;
    tick();
    chk_b("s3_inc", 16, 1'b0, 1'b1, 1'b0);
    b_bhv = B_LOAD; b_ld = 5'd2;
    tick();
    chk_b("s3_load2", 2, 1'b0, 1'b0, 1'b0);
    b_bhv = B_DEC;
    tick();
    chk_b("s3_dec", 0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_b("s3_dec_hold", 0, 1'b0, 1'b0, 1'b0);

    // Wrap mode between 1 and 5, starting from reset value 4
    chk_c("wr_rst", 4, 1'b0, 1'b0, 1'b0);
    c_rst = 1'b1; c_bhv = B_INC;
    tick();
    chk_c("wr_inc5", 5, 1'b0, 1'b1, 1'b0);
    tick();
    chk_c("wr_wrap_up", 1, 1'b0, 1'b0, 1'b1);
    c_bhv = B_DEC;
    tick();
    chk_c("wr_wrap_dn", 5, 1'b0, 1'b0, 1'b1);
    tick();
    chk_c("wr_dec4", 4, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
